tcu_fedp_seq: RTL
=================

# tcu_fedp_seq

K-step accumulation sequencer that sits directly upstream of the tensor-core FEDP (fused element dot-product) unit. It accepts one dot-product request: a format pair, an initial accumulator and a step count. It then streams `steps` operand chunks (N packed XLEN words of A and of B per chunk) into the FEDP one at a time. Each chunk's FEDP result is fed back as the `c` input of the next chunk, and the final FP32 accumulator is returned on a valid/ready response port. It owns all FEDP timing: enable gating, issue spacing, and capture at exactly LATENCY cycles after issue.

## Interface
- `N`, default 2: XLEN words per operand row/col chunk (2N 16-bit elements); must match the FEDP `N`.
- `LATENCY`, default 4: FEDP pipeline latency in enable-high cycles; must equal the FEDP `LATENCY`; ≥1.
- `MAX_STEPS`, default 8: maximum chunks per request; SW = $clog2(MAX_STEPS+1).
- `clk` in 1: clock.
- `reset` in 1: reset; one clock; reset is asynchronous and active-low.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_fmt_s` in 3, `req_fmt_d` in 3: source/destination format codes (2=fp16, 3=bf16 for source).
- `req_c` in XLEN: initial FP32 accumulator, bits [31:0].
- `req_steps` in SW: chunk count, 0..MAX_STEPS.
- `op_valid` in 1, `op_ready` out 1: operand chunk handshake.
- `op_a` in N×XLEN, `op_b` in N×XLEN: operand chunk.
- `fedp_enable` out 1: FEDP pipeline enable.
- `fedp_fmt_s` out 3, `fedp_fmt_d` out 3: latched request formats.
- `fedp_a_row` out N×XLEN, `fedp_b_col` out N×XLEN, `fedp_c_val` out XLEN: FEDP inputs.
- `fedp_d_val` in XLEN: FEDP result.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out XLEN: final accumulator.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, FETCH, WAIT, DONE. Registers: `fmt_s/fmt_d`, `acc[31:0]`, `steps_left[SW]`, `first` flag, `wcnt` ($clog2(LATENCY) bits, min 1).
- IDLE: `req_ready`=1. On request handshake, latch fmts, `acc<=req_c[31:0]`, `steps_left<=req_steps`, `first<=1`. If `req_steps==0`, go to DONE; else go to FETCH.
- FETCH: `op_ready`=1, `fedp_enable`=1. `fedp_a_row/b_col` = `op_a/op_b` (combinational pass-through). `fedp_c_val` = zero-extended `acc`.
  - On op handshake (issue): `steps_left--`, `wcnt<=LATENCY-1`, go to WAIT.
  - Without a handshake, stay in FETCH. Garbage entering the FEDP is ignored, because capture is timed from the issue only.
- WAIT: `fedp_enable`=1, `op_ready`=0.
  - If `wcnt==0`: `acc<=fedp_d_val[31:0]`, `first<=0`. Go to DONE if `steps_left==0`, else go to FETCH.
  - Otherwise `wcnt--`.
- DONE: `rsp_valid`=1, `rsp_data`=zero-extended `acc`, stable until `rsp_ready`. On handshake, go to IDLE.
- `fedp_enable`=0 in IDLE and DONE. `fedp_fmt_*` always drive the latched registers.
- Requests with `req_steps > MAX_STEPS` are illegal; behaviour is undefined and flagged by an assertion.
- No arithmetic inside the block: all FP math is in the FEDP. `acc` is a pure register.

## Timing
- Reset (async assert, sync release) forces: state=IDLE, `req_ready`=1, `op_ready`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `fedp_enable`=0, `acc`=0, latched fmts=0.
- Reset mid-operation aborts the request with no response. Stale FEDP pipeline contents are never captured.
- Issue in cycle t → `fedp_d_val` is valid in cycle t+LATENCY, captured at the end of that cycle. The next FETCH is cycle t+LATENCY+1, so the minimum step period is LATENCY+1.
- With operands always valid and the request accepted in cycle r, `rsp_valid` rises in cycle r + S·(LATENCY+1) + 1. For S=0, it rises in r+1.
- `req_ready` is low from the acceptance cycle +1 until the cycle after the response handshake. No back-to-back overlap.
- `op_valid` arriving while in WAIT/IDLE/DONE is not accepted (`op_ready`=0).

## Test plan
- Use a bench FEDP model: LATENCY=4 enable-gated pipe computing Σ(a·b) in fp16 + c in fp32. Set fmt_s=2, all `op_a` halves 0x3C00 (1.0), all `op_b` halves 0x4000 (2.0), req_c=0x3F800000, steps=3, ops always valid → `rsp_data`=0x41C80000 (25.0) at r+16. `op_ready` pulses exactly 3 times, spaced 5 cycles apart.
- steps=0, req_c=0x40490FDB → `rsp_valid` in r+1 with 0x40490FDB. `op_ready` and `fedp_enable` never assert.
- steps=2, delay the second `op_valid` by 7 cycles → same sum as without the delay (1+16=17.0=0x41880000). The first-step result is held in `acc` and fed as `fedp_c_val`.
- Hold `rsp_ready`=0 for 10 cycles in DONE → `rsp_valid`/`rsp_data` stay stable, `req_ready`=0, `fedp_enable`=0. Release → IDLE the next cycle.
- Assert `reset` low in WAIT of step 2 of 3 → all outputs at reset values immediately (async). A new request after release, steps=1, c=0 → 0x41000000 (8.0), uncorrupted by the stale pipeline.
- fmt_s=3 with bf16 halves 0x3F80×0x4000, steps=1, c=0 → `fedp_fmt_s`=3 throughout, result 0x41000000.

Source files
------------

// File: rtl/tcu_fedp_seq.sv
// K-step accumulation sequencer in front of the tensor-core FEDP unit.
// Streams operand chunks, feeds each result back as c, returns final FP32.
module tcu_fedp_seq #(
  parameter int N         = 2,
  parameter int LATENCY   = 4,
  parameter int MAX_STEPS = 8,
  parameter int XLEN      = 32,
  localparam int SW       = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt_s,
  input  logic [2:0]        req_fmt_d,
  input  logic [XLEN-1:0]   req_c,
  input  logic [SW-1:0]     req_steps,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [N*XLEN-1:0] op_a,
  input  logic [N*XLEN-1:0] op_b,
  output logic              fedp_enable,
  output logic [2:0]        fedp_fmt_s,
  output logic [2:0]        fedp_fmt_d,
  output logic [N*XLEN-1:0] fedp_a_row,
  output logic [N*XLEN-1:0] fedp_b_col,
  output logic [XLEN-1:0]   fedp_c_val,
  input  logic [XLEN-1:0]   fedp_d_val,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              busy
);

  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WW-1:0] WLOAD = WW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [2:0]    fmt_s;
  logic [2:0]    fmt_d;
  logic [31:0]   acc;
  logic [SW-1:0] steps_left;
  logic          first;
  logic [WW-1:0] wcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fmt_s      <= '0;
      fmt_d      <= '0;
      acc        <= '0;
      steps_left <= '0;
      first      <= 1'b0;
      wcnt       <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            fmt_s      <= req_fmt_s;
            fmt_d      <= req_fmt_d;
            acc        <= req_c[31:0];
            steps_left <= req_steps;
            first      <= 1'b1;
          end
        end
        FETCH: begin
          if (op_valid) begin
            steps_left <= steps_left - 1'b1;
            wcnt       <= WLOAD;
          end
        end
        WAIT: begin
          // capture is timed only from the issue, never from pipe contents
          if (wcnt == '0) begin
            acc   <= fedp_d_val[31:0];
            first <= 1'b0;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    op_ready    = 1'b0;
    fedp_enable = 1'b0;
    rsp_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nx = (req_steps == '0) ? DONE : FETCH;
      end
      FETCH: begin
        op_ready    = 1'b1;
        fedp_enable = 1'b1;
        if (op_valid)
          state_nx = WAIT;
      end
      WAIT: begin
        fedp_enable = 1'b1;
        if (wcnt == '0)
          state_nx = (steps_left == '0) ? DONE : FETCH;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign fedp_fmt_s = fmt_s;
  assign fedp_fmt_d = fmt_d;
  assign fedp_a_row = op_a;
  assign fedp_b_col = op_b;
  assign fedp_c_val = XLEN'(acc);
  assign rsp_data   = rsp_valid ? XLEN'(acc) : '0;

  req_steps_legal: assert property (
    @(posedge clk) disable iff (!reset)
    (req_valid && req_ready) |-> (req_steps <= SW'(MAX_STEPS))
  );

  first_clears: assert property (
    @(posedge clk) disable iff (!reset)
    (state == WAIT && wcnt == '0) |=> !first
  );

endmodule
